// File: rtl/text_buffer_arbiter.sv
// Text buffer for the VGA text renderer: round-robin write port for two requesters,
// cursor and control-byte decode. Define VSYNC_GATE_EN to confine updates to vsync.
module text_buffer_arbiter #(
  parameter int unsigned NCHARS     = 64,
  parameter int unsigned LINE_LEN   = 32,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_a,
  input  logic [7:0]                 data_a,
  output logic                       ack_a,
  input  logic                       req_b,
  input  logic [7:0]                 data_b,
  output logic                       ack_b,
  input  logic                       clr,
  input  logic                       vsync,
  output logic [NCHARS-1:0][7:0]     chars,
  output logic [$clog2(NCHARS)-1:0]  cursor,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(NCHARS);
  // LINE_LEN divides a power of two, so a line start is the cursor with these bits cleared.
  localparam logic [CW-1:0] LINE_MASK = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NCHARS - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                  state_q, state_d;
  logic [NCHARS-1:0][7:0]  chars_q;
  logic [CW-1:0]           cursor_q, cursor_d;
  logic [CW-1:0]           clr_idx_q, clr_idx_d;
  logic                    last_grant_q, last_grant_d;  // 1 = requester B

  logic                    wr_en;
  logic [CW-1:0]           wr_idx;
  logic [7:0]              wr_data;

  logic                    gate;
  logic                    grant_a, grant_b;
  logic                    xfer;
  logic [7:0]              xfer_data;

`ifdef VSYNC_GATE_EN
  logic vs_meta_q, vs_s_q;

  // Reset to the inactive (high) level so nothing is written until a real sync pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_meta_q <= 1'b1;
      vs_s_q    <= 1'b1;
    end else begin
      vs_meta_q <= vsync;
      vs_s_q    <= vs_meta_q;
    end
  end

  assign gate = ~vs_s_q;
`else
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign gate         = 1'b1;
`endif

  assign grant_a   = req_a && (!req_b || last_grant_q);
  assign grant_b   = req_b && (!req_a || !last_grant_q);
  assign ack_a     = (state_q == StIdle) && !clr && gate && grant_a;
  assign ack_b     = (state_q == StIdle) && !clr && gate && grant_b;
  assign xfer      = ack_a || ack_b;
  assign xfer_data = ack_a ? data_a : data_b;

  always_comb begin
    state_d      = state_q;
    cursor_d     = cursor_q;
    clr_idx_d    = clr_idx_q;
    last_grant_d = last_grant_q;
    wr_en        = 1'b0;
    wr_idx       = cursor_q;
    wr_data      = xfer_data;

    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d   = StClear;
          clr_idx_d = '0;
        end else if (xfer) begin
          last_grant_d = ack_b;
          if (xfer_data >= 8'h20 && xfer_data <= 8'h7e) begin
            wr_en    = 1'b1;
            cursor_d = cursor_q + 1'b1;
          end else begin
            case (xfer_data)
              8'h08: begin
                if (cursor_q != '0) begin
                  cursor_d = cursor_q - 1'b1;
                  wr_en    = 1'b1;
                  wr_idx   = cursor_q - 1'b1;
                  wr_data  = BLANK_CHAR;
                end
              end
              8'h0a: cursor_d = (cursor_q | LINE_MASK) + 1'b1;
              8'h0c: begin
                state_d   = StClear;
                clr_idx_d = '0;
              end
              default: ;
            endcase
          end
        end
      end

      StClear: begin
        if (gate) begin
          wr_en   = 1'b1;
          wr_idx  = clr_idx_q;
          wr_data = BLANK_CHAR;
          if (clr_idx_q == LAST_IDX) begin
            clr_idx_d = '0;
            cursor_d  = '0;
            state_d   = StIdle;
          end else begin
            clr_idx_d = clr_idx_q + 1'b1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      chars_q      <= {NCHARS{BLANK_CHAR}};
      cursor_q     <= '0;
      clr_idx_q    <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cursor_q     <= cursor_d;
      clr_idx_q    <= clr_idx_d;
      last_grant_q <= last_grant_d;
      if (wr_en) chars_q[wr_idx] <= wr_data;
    end
  end

  assign chars  = chars_q;
  assign cursor = cursor_q;
  assign busy   = (state_q == StClear);

endmodule
